// File: rtl/top_alu_if.sv
// Board pin bundle for the ALU wrapper: buttons and switches in, LEDs and display out.
interface top_alu_if;
    logic       PB0;
    logic       PB1;
    logic       PB2;
    logic [7:0] SW;
    logic [7:0] LED;
    logic [3:0] AN;
    logic [6:0] seg;

    // Board side: drives buttons and switches, observes indicators.
    modport master (
        output PB0, PB1, PB2, SW,
        input  LED, AN, seg
    );

    // ALU side: samples buttons and switches, drives indicators.
    modport slave (
        input  PB0, PB1, PB2, SW,
        output LED, AN, seg
    );
endinterface

// File: rtl/top_alu.sv
// 8-bit board ALU: debounced buttons load A, B and opcode from the switches;
// the 16-bit result goes to the LEDs (low byte) and a 4-digit hex display.
module top_alu #(
    parameter int DEBOUNCE_BITS = 18,
    parameter int REFRESH_BITS  = 18
) (
    input  logic        clk,
    input  logic        rst,
    top_alu_if.slave    bus
);

    logic [2:0]               r_pb_s1;
    logic [2:0]               r_pb_s2;
    logic [2:0]               r_db_lvl;
    logic [2:0]               r_db_prev;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt [3];
    logic [2:0]               w_pulse;
    logic [7:0]               r_sw_s1;
    logic [7:0]               r_sw_s2;
    logic [7:0]               r_a;
    logic [7:0]               r_b;
    logic [2:0]               r_op;
    logic [15:0]              r_res_p1;
    logic [REFRESH_BITS-1:0]  r_ref;
    logic [1:0]               w_dig;
    logic [3:0]               w_nib;
    logic [3:0]               r_an;
    logic [6:0]               r_seg;

    // Result of one opcode; operands zero-extended, everything modulo 2^16.
    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        logic [15:0] a16;
        logic [15:0] b16;
        a16 = {8'h00, a};
        b16 = {8'h00, b};
        alu_calc = 16'h0000;
        case (op)
            3'd0:    alu_calc = a16 + b16;
            3'd1:    alu_calc = a16 - b16;
            3'd2:    alu_calc = a16 * b16;
            3'd3:    alu_calc = a16 & b16;
            3'd4:    alu_calc = a16 | b16;
            3'd5:    alu_calc = a16 ^ b16;
            3'd6:    alu_calc = {8'h00, ~a};
            default: alu_calc = a16 << b[3:0];
        endcase
    endfunction

    // Active-low seven-segment pattern, returned as {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        hex_seg = 7'b1000000;
        case (nib)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    // Two-flop synchronizers for the asynchronous buttons and switches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pb_s1 <= '0;
            r_pb_s2 <= '0;
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_pb_s1 <= {bus.PB2, bus.PB1, bus.PB0};
            r_pb_s2 <= r_pb_s1;
            r_sw_s1 <= bus.SW;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Debounce: accept a new level only after 2^DEBOUNCE_BITS consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_db_lvl  <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_db_prev <= r_db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (r_pb_s2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (&r_db_cnt[i]) begin
                    r_db_lvl[i] <= r_pb_s2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DEBOUNCE_BITS'(1);
                end
            end
        end
    end

    // One-cycle press pulse on each rising debounced level.
    assign w_pulse = r_db_lvl & ~r_db_prev;

    // Operand/opcode registers and the result; simultaneous pulses all load together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_res_p1 <= '0;
        end else begin
            if (w_pulse[0]) r_a  <= r_sw_s2;
            if (w_pulse[1]) r_b  <= r_sw_s2;
            if (w_pulse[2]) r_op <= r_sw_s2[2:0];
            r_res_p1 <= alu_calc(r_a, r_b, r_op);
        end
    end

    // ---- display stage: digit select from the refresh counter's top bits ----
    assign w_dig = r_ref[REFRESH_BITS-1 -: 2];
    assign w_nib = r_res_p1[{w_dig, 2'b00} +: 4];

    // Refresh counter plus digit enable and pattern registered as a matched pair.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ref <= '0;
            r_an  <= 4'b1110;
            r_seg <= 7'b1000000;
        end else begin
            r_ref <= r_ref + REFRESH_BITS'(1);
            r_an  <= ~(4'b0001 << w_dig);
            r_seg <= hex_seg(w_nib);
        end
    end

    assign bus.LED = r_res_p1[7:0];
    assign bus.AN  = r_an;
    assign bus.seg = r_seg;

endmodule

// File: tb/tb_top_alu.sv
// Self-checking bench for top_alu with short debounce/refresh periods.
module tb_top_alu;
    localparam int DB     = 4;
    localparam int RB     = 6;
    localparam int DB_CYC = 1 << DB;
    localparam int FRAME  = 1 << RB;

    logic clk;
    logic rst;
    top_alu_if bus();

    top_alu #(.DEBOUNCE_BITS(DB), .REFRESH_BITS(RB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    int m_a = 0, m_b = 0, m_op = 0;
    logic [6:0] seg_tab [16];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #4ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b + 65536;
            2: r = a * b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = 255 - a;
            default: r = a * (1 << (b % 16));
        endcase
        return 16'(r % 65536);
    endfunction

    task automatic press(input logic [2:0] btns, input logic [7:0] sw);
        bus.SW = sw;
        repeat (4) tick();
        bus.PB0 = btns[0];
        bus.PB1 = btns[1];
        bus.PB2 = btns[2];
        repeat (DB_CYC + 8) tick();
        bus.PB0 = 1'b0;
        bus.PB1 = 1'b0;
        bus.PB2 = 1'b0;
        repeat (DB_CYC + 8) tick();
    endtask

    task automatic model_load(input logic [2:0] btns, input logic [7:0] sw);
        if (btns[0]) m_a  = int'(sw);
        if (btns[1]) m_b  = int'(sw);
        if (btns[2]) m_op = int'(sw[2:0]);
    endtask

    // Walk one refresh frame and check every digit's pattern against exp.
    task automatic check_display(input string tag, input logic [15:0] exp);
        logic [3:0] an_exp;
        logic [3:0] nib;
        bit found;
        for (int d = 0; d < 4; d++) begin
            an_exp = 4'b1111;
            an_exp[d] = 1'b0;
            found = 1'b0;
            for (int k = 0; k < FRAME + 8 && !found; k++) begin
                tick();
                if (bus.AN === an_exp) found = 1'b1;
            end
            if (!found) begin
                check({tag, "_an"}, {12'h0, bus.AN}, {12'h0, an_exp});
            end else begin
                nib = exp[4*d +: 4];
                check($sformatf("%s_seg%0d", tag, d), {9'h0, bus.seg}, {9'h0, seg_tab[nib]});
            end
        end
    endtask

    initial begin
        logic [15:0] exp_r;
        logic [15:0] sweep [8];
        logic [2:0]  mask;
        logic [7:0]  sw;
        logic [7:0]  sw_first;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
        sweep[1] = 16'h00F0; sweep[2] = 16'h0EF1; sweep[3] = 16'h000F;
        sweep[4] = 16'h00FF; sweep[5] = 16'h00F0; sweep[6] = 16'h0000;
        sweep[7] = 16'h8000;

        // Reset
        rst = 1'b0;
        bus.PB0 = 1'b0; bus.PB1 = 1'b0; bus.PB2 = 1'b0; bus.SW = 8'h00;
        repeat (2) tick();
        check("rst_led", {8'h0, bus.LED}, 16'h0000);
        check("rst_an",  {12'h0, bus.AN}, 16'h000E);
        check("rst_seg", {9'h0, bus.seg}, 16'h0040);

        // Digit scan order after reset release
        rst = 1'b1;
        repeat (9) tick();
        for (int j = 0; j < 4; j++) begin
            if (j > 0) repeat (FRAME / 4) tick();
            check($sformatf("scan_an%0d", j), {12'h0, bus.AN}, {12'h0, ~(4'b0001 << j)});
            check($sformatf("scan_seg%0d", j), {9'h0, bus.seg}, 16'h0040);
        end

        // Operand load: A=FF, B=0F, ADD
        press(3'b001, 8'hFF); model_load(3'b001, 8'hFF);
        press(3'b010, 8'h0F); model_load(3'b010, 8'h0F);
        check("load_led", {8'h0, bus.LED}, 16'h000E);
        check_display("load_disp", 16'h010E);

        // Opcode sweep
        for (int op = 1; op < 8; op++) begin
            press(3'b100, 8'(op)); model_load(3'b100, 8'(op));
            check($sformatf("sweep%0d_led", op), {8'h0, bus.LED}, {8'h0, sweep[op][7:0]});
            check_display($sformatf("sweep%0d", op), sweep[op]);
        end

        // Back to ADD, then bounce on PB0 with SW=55 must not load
        press(3'b100, 8'h00); model_load(3'b100, 8'h00);
        bus.SW = 8'h55;
        repeat (4) tick();
        for (int t = 0; t < 10; t++) begin
            bus.PB0 = ~bus.PB0;
            repeat (2) tick();
        end
        bus.PB0 = 1'b0;
        repeat (DB_CYC + 8) tick();
        exp_r = ref_alu(m_a, m_b, m_op);
        check("bounce_led", {8'h0, bus.LED}, {8'h0, exp_r[7:0]});
        check_display("bounce", exp_r);
        press(3'b001, 8'h55); model_load(3'b001, 8'h55);
        exp_r = ref_alu(m_a, m_b, m_op);
        check("stable_led", {8'h0, bus.LED}, {8'h0, exp_r[7:0]});

        // Long hold on PB1 with SW changing after the pulse
        bus.SW = 8'h21;
        repeat (4) tick();
        bus.PB1 = 1'b1;
        repeat (DB_CYC + 8) tick();
        bus.SW = 8'hC3;
        repeat (3 * DB_CYC) tick();
        bus.PB1 = 1'b0;
        repeat (DB_CYC + 8) tick();
        model_load(3'b010, 8'h21);
        exp_r = ref_alu(m_a, m_b, m_op);
        check_display("hold", exp_r);

        // Simultaneous PB0 + PB2: new opcode and new A used together
        press(3'b101, 8'h0E); model_load(3'b101, 8'h0E);
        exp_r = ref_alu(m_a, m_b, m_op);
        check_display("simul", exp_r);

        // Reset mid-debounce with PB0 held through release
        bus.SW = 8'h3C;
        repeat (4) tick();
        bus.PB0 = 1'b1;
        repeat (DB_CYC / 2) tick();
        rst = 1'b0;
        repeat (2) tick();
        m_a = 0; m_b = 0; m_op = 0;
        check("midrst_led", {8'h0, bus.LED}, 16'h0000);
        check("midrst_an",  {12'h0, bus.AN}, 16'h000E);
        check("midrst_seg", {9'h0, bus.seg}, 16'h0040);
        rst = 1'b1;
        repeat (DB_CYC + 8) tick();
        model_load(3'b001, 8'h3C);
        bus.PB0 = 1'b0;
        repeat (DB_CYC + 8) tick();
        check("midrst_load_led", {8'h0, bus.LED}, 16'h003C);
        check_display("midrst_load", ref_alu(m_a, m_b, m_op));

        // Randomized presses against the reference model
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 5))
                0: mask = 3'b001;
                1: mask = 3'b010;
                2: mask = 3'b100;
                3: mask = 3'b101;
                4: mask = 3'b111;
                default: mask = 3'b011;
            endcase
            sw = 8'($urandom);
            press(mask, sw);
            model_load(mask, sw);
            exp_r = ref_alu(m_a, m_b, m_op);
            check($sformatf("rnd%0d_led", it), {8'h0, bus.LED}, {8'h0, exp_r[7:0]});
            if (it % 4 == 3) check_display($sformatf("rnd%0d", it), exp_r);
        end

        sw_first = 8'h00;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + int'(sw_first));
        $finish;
    end
endmodule

// File: doc/top_alu.md
# top_alu

Board-level 8-bit ALU wrapper for a 50 MHz FPGA board with three push buttons, eight slide switches, eight LEDs and a 4-digit multiplexed 7-segment display. Operands A and B and a 3-bit opcode are captured from the switches by debounced button presses. The 16-bit result is driven on the LEDs (low byte) and shown as four hex digits on the display. It is the top-level block, with board pins connected directly.

## Interface
- DEBOUNCE_BITS, 18: debounce counter width; a button level is accepted after 2^DEBOUNCE_BITS consecutive stable cycles (5.24 ms at 50 MHz).
- REFRESH_BITS, 18: display refresh counter width; its top 2 bits select the active digit (2^16 cycles = 1.31 ms per digit).
- clk  in  1  system clock, 50 MHz, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- PB0  in  1  asynchronous button: load operand A from SW.
- PB1  in  1  asynchronous button: load operand B from SW.
- PB2  in  1  asynchronous button: load opcode from SW[2:0].
- SW  in  8  slide switches, asynchronous.
- LED  out  8  result[7:0].
- AN  out  4  digit enables, active-low, AN[0] = rightmost digit.
- seg  out  7  segment cathodes, active-low, seg[0]=a … seg[6]=g.

## Operation
- Each PBx passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input differs from it for 2^DEBOUNCE_BITS consecutive cycles. Any bounce restarts the count.
- A 0→1 transition of a debounced level produces a one-cycle pulse. Holding a button produces exactly one pulse, and release produces none.
- SW is sampled through a 2-flop synchronizer.
- On the pulse cycle:
  - PB0 loads A ← SW.
  - PB1 loads B ← SW.
  - PB2 loads OP ← SW[2:0].
- Simultaneous pulses each load their own register in the same cycle.
- The result register R[15:0] is recomputed every cycle from A, B and OP. Operands are zero-extended to 16 bits, and all arithmetic is modulo 2^16.
  - 000 ADD: A+B.
  - 001 SUB: A−B (wraps, e.g. 0−1 = FFFF).
  - 010 MUL: A×B.
  - 011 AND: A&B.
  - 100 OR: A|B.
  - 101 XOR: A^B.
  - 110 NOT: {8'h00, ~A}.
  - 111 SHL: A << B[3:0], truncated to 16 bits.
- LED = R[7:0], registered.
- Display:
  - The top 2 bits of the free-running refresh counter select the digit index d (0..3). Digit d shows hex nibble R[4d+3:4d].
  - AN has exactly one bit low, at index d.
  - seg is the active-low hex pattern of that nibble. Required patterns, as seg[6:0]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - AN and seg are registered together, so they never show a mismatched digit/pattern pair.

## Timing
- Reset values (rst low at a rising edge):
  - A=0, B=0, OP=0, R=0, LED=8'h00.
  - Refresh counter=0, AN=4'b1110, seg=7'b1000000.
  - Debounced levels=0, debounce counters=0, synchronizers=0.
- If a button is held through reset release, it produces one pulse after the debounce period.
- Press latency: 2 synchronizer cycles + 2^DEBOUNCE_BITS cycles to the pulse. The register loads on the edge ending the pulse cycle. R and LED update 1 cycle later. The display shows the new value within one refresh frame (2^REFRESH_BITS cycles).
- If PB2 and PB0 pulse in the same cycle, the next R uses both the new OP and the new A.
- Changing SW without a press has no effect. Changing A or B after OP is loaded updates R on the next cycle.
- Reset mid-debounce discards the partial count. Reset mid-refresh restarts at digit 0.
- The refresh counter wraps freely, and the digit order is 0,1,2,3,0…

## Test plan
- Reset: hold rst=0 for 2 cycles → LED=00, AN=1110, seg=1000000. After release, AN steps through 1110→1101→1011→0111 every 2^16 cycles, and all digits show 0.
- Operand load: SW=FF, PB0 held 10 ms; then SW=0F, PB1 held 10 ms → A=FF, B=0F, and OP=0 (ADD) gives R=010E, LED=0E, display "010E".
- Opcode sweep with A=FF, B=0F, pressing PB2 with SW=1..7 → R = 00F0, 0EF1, 000F, 00FF, 00F0, 0000, 8000 respectively, with LED equal to the low byte.
- Bounce rejection: toggle PB0 every 2 µs for 20 µs, then release, with SW=55 → A is unchanged. A single stable 10 ms press with SW=55 → exactly one load, A=55.
- Hold and release: press PB1 for 50 ms while SW changes mid-press → B holds the value sampled at the pulse, and release causes no load.
- Reset mid-operation: assert rst during a PB0 debounce count → A stays 0, all outputs return to reset values, and a still-held PB0 loads A one debounce period after release.
